ctl_round: RTL and testbench



---
 rtl/ctl_pkg.sv | 38 +++
 rtl/ctl_round_lfsr16.sv | 28 ++
 rtl/ctl_round.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ctl_round.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_pkg.sv
// ctl_pkg: shared types and constants for the duck round sequencer.
// Holds the sequencer state encoding, the LFSR seed/taps and the
// screen-derived launch limits used by ctl_round and lfsr16.
package ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_FLYING,
    ST_HIT,
    ST_FLY_AWAY,
    ST_NEXT,
    ST_ROUND_END,
    ST_GAME_OVER
  } state_t;

  // Fibonacci LFSR: seed and feedback taps 16,15,13,4 (bits 15,14,12,3)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  // Leftmost launch column; the random offset spans 0..511 above it
  localparam logic [9:0] START_X_MIN = 10'd256;

  // Largest speed the duck position controller accepts
  localparam logic [4:0] SPD_MAX = 5'd31;

  // Adds a small random jitter to a base speed, clamping at SPD_MAX
  function automatic logic [4:0] sat_add_spd(input logic [4:0] base,
                                             input logic [1:0] jitter);
    logic [5:0] sum;
    sum = {1'b0, base} + {4'b0000, jitter};
    if (sum > {1'b0, SPD_MAX}) begin
      return SPD_MAX;
    end
    return sum[4:0];
  endfunction

endpackage

// File: rtl/ctl_round_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR used as the random source
// for duck launch parameters. Shifts left every clock; the feedback bit is
// the XOR of the tapped bits and enters at bit 0.
module lfsr16
  import ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_value
);

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = ^(r_state & LFSR_TAPS);

  // Shift register steps every cycle and restarts from the seed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign o_value = r_state;

endmodule

// File: rtl/ctl_round.sv
// ctl_round: round/game sequencer for the duck datapath.
// Launches ducks with random start position/direction/speed, counts shots
// and hits, ends each duck by hit, exhausted shots or timeout, and decides
// whether the round passes or the game ends.
// Build option: define CTL_ROUND_SPEEDUP_EN to raise the base duck speed by
// 2 pixels/frame per round (capped at 27); otherwise speed stays BASE_SPD.
module ctl_round
  import ctl_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int FLY_FRAMES      = 300,
  parameter int HOLD_FRAMES     = 60,
  parameter int HITS_TO_PASS    = 6,
  parameter int BASE_SPD        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start,
  input  logic       shot,
  input  logic       shot_on_duck,
  output logic       duck_launch,
  output logic       duck_fly_away,
  output logic       duck_dead,
  output logic       duck_direction,
  output logic [4:0] duck_v_spd,
  output logic [4:0] duck_h_spd,
  output logic [9:0] duck_start_x,
  output logic [1:0] shots_left,
  output logic [3:0] hits,
  output logic [3:0] duck_idx,
  output logic [3:0] round_num,
  output logic       game_over
);

  localparam int FRAME_MAX = (FLY_FRAMES > HOLD_FRAMES) ? FLY_FRAMES : HOLD_FRAMES;
  localparam int FCW       = $clog2(FRAME_MAX + 1);

  localparam logic [FCW-1:0] FLY_LAST   = FCW'(FLY_FRAMES - 1);
  localparam logic [FCW-1:0] HOLD_LAST  = FCW'(HOLD_FRAMES - 1);
  localparam logic [3:0]     LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]     PASS_HITS  = 4'(HITS_TO_PASS);
  localparam logic [1:0]     SHOTS_INIT = 2'(SHOTS_PER_DUCK);
  localparam logic [4:0]     BASE_SPD_V = 5'(BASE_SPD);

  state_t r_state;
  state_t w_next;

  logic [FCW-1:0] r_frame_cnt;
  logic [1:0]     r_shots_left;
  logic [3:0]     r_hits;
  logic [3:0]     r_duck_idx;
  logic [3:0]     r_round;
  logic           r_launch;
  logic           r_fly_away;
  logic           r_dead;
  logic           r_game_over;
  logic           r_direction;
  logic [4:0]     r_v_spd;
  logic [4:0]     r_h_spd;
  logic [9:0]     r_start_x;

  logic [15:0] w_rnd;
  logic [1:0]  w_rnd_unused;
  logic        w_hit_shot;
  logic        w_miss_shot;
  logic        w_fly_timeout;
  logic        w_hold_done;
  logic        w_round_pass;
  logic        w_start_game;
  logic        w_new_round;
  logic        w_enter_launch;
  logic        w_score_hit;
  logic        w_advance_duck;
  logic        w_frame_state;
  logic [3:0]  w_round_next;
  logic [4:0]  w_speed;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_value (w_rnd)
  );

  // The top two random bits are not needed by any launch parameter
  assign w_rnd_unused = w_rnd[15:14];

  // A shot only counts while the duck is flying; a miss with no shots left
  // cannot occur because FLYING is left as soon as the count hits zero
  assign w_hit_shot     = shot && shot_on_duck;
  assign w_miss_shot    = (r_state == ST_FLYING) && shot && !shot_on_duck &&
                          (r_shots_left != 2'd0);
  assign w_fly_timeout  = new_frame && (r_frame_cnt == FLY_LAST);
  assign w_hold_done    = new_frame && (r_frame_cnt == HOLD_LAST);
  assign w_round_pass   = (r_hits >= PASS_HITS);
  assign w_start_game   = (r_state == ST_IDLE) && start;
  assign w_new_round    = (r_state == ST_ROUND_END) && w_round_pass;
  assign w_enter_launch = (w_next == ST_LAUNCH);
  assign w_score_hit    = (r_state == ST_FLYING) && (w_next == ST_HIT);
  assign w_advance_duck = (r_state == ST_NEXT) && (w_next == ST_LAUNCH);
  assign w_frame_state  = (r_state == ST_FLYING) || (r_state == ST_HIT) ||
                          (r_state == ST_FLY_AWAY);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decision; in FLYING an exhausted shot count wins, then a hit,
  // then the timeout, so a miss on the timeout frame still flies away
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_next = ST_FLYING;
      end
      ST_FLYING: begin
        if (r_shots_left == 2'd0) begin
          w_next = ST_FLY_AWAY;
        end else if (w_hit_shot) begin
          w_next = ST_HIT;
        end else if (w_fly_timeout) begin
          w_next = ST_FLY_AWAY;
        end
      end
      ST_HIT, ST_FLY_AWAY: begin
        if (w_hold_done) begin
          w_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_next = (r_duck_idx == LAST_DUCK) ? ST_ROUND_END : ST_LAUNCH;
      end
      ST_ROUND_END: begin
        w_next = w_round_pass ? ST_LAUNCH : ST_GAME_OVER;
      end
      ST_GAME_OVER: begin
        if (start) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Round number after this edge, so a launch in a new round already uses it
  always_comb begin
    w_round_next = r_round;
    if (w_start_game) begin
      w_round_next = 4'd1;
    end else if (w_new_round && (r_round != 4'hF)) begin
      w_round_next = r_round + 4'd1;
    end
  end

`ifdef CTL_ROUND_SPEEDUP_EN
  localparam logic [6:0] SPD_RAMP_MAX = 7'd27;
  logic [6:0] w_ramp;

  // Base speed grows by 2 per round beyond the first, capped below SPD_MAX
  // so the random jitter still has headroom
  always_comb begin
    w_ramp  = 7'(BASE_SPD) + {2'b00, w_round_next - 4'd1, 1'b0};
    w_speed = w_ramp[4:0];
    if (w_ramp > SPD_RAMP_MAX) begin
      w_speed = SPD_RAMP_MAX[4:0];
    end
  end
`else
  assign w_speed = BASE_SPD_V;
`endif

  // Frame counter times both the flight and the HIT/FLY_AWAY hold; it
  // restarts on every state change and only advances on new_frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_next != r_state) begin
      r_frame_cnt <= '0;
    end else if (new_frame && w_frame_state) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // State-derived flags are registered from the next state so they change
  // on the edge that enters the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_launch    <= 1'b0;
      r_dead      <= 1'b0;
      r_fly_away  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_launch    <= (w_next == ST_LAUNCH);
      r_dead      <= (w_next == ST_HIT);
      r_fly_away  <= (w_next == ST_FLY_AWAY);
      r_game_over <= (w_next == ST_GAME_OVER);
    end
  end

  // Launch parameters and shot budget are loaded on entry to LAUNCH and
  // then held until the next launch; misses consume shots while flying
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_direction  <= 1'b0;
      r_v_spd      <= 5'd0;
      r_h_spd      <= 5'd0;
      r_start_x    <= 10'd0;
      r_shots_left <= 2'd0;
    end else if (w_enter_launch) begin
      r_direction  <= w_rnd[9];
      r_v_spd      <= sat_add_spd(w_speed, w_rnd[11:10]);
      r_h_spd      <= sat_add_spd(w_speed, w_rnd[13:12]);
      r_start_x    <= START_X_MIN + {1'b0, w_rnd[8:0]};
      r_shots_left <= SHOTS_INIT;
    end else if (w_miss_shot) begin
      r_shots_left <= r_shots_left - 2'd1;
    end
  end

  // Score and progress counters: cleared at game start and on a passed
  // round, hits saturate at 15, round number follows w_round_next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits     <= 4'd0;
      r_duck_idx <= 4'd0;
      r_round    <= 4'd0;
    end else begin
      r_round <= w_round_next;
      if (w_start_game || w_new_round) begin
        r_hits     <= 4'd0;
        r_duck_idx <= 4'd0;
      end else begin
        if (w_score_hit && (r_hits != 4'hF)) begin
          r_hits <= r_hits + 4'd1;
        end
        if (w_advance_duck) begin
          r_duck_idx <= r_duck_idx + 4'd1;
        end
      end
    end
  end

  assign duck_launch    = r_launch;
  assign duck_fly_away  = r_fly_away;
  assign duck_dead      = r_dead;
  assign duck_direction = r_direction;
  assign duck_v_spd     = r_v_spd;
  assign duck_h_spd     = r_h_spd;
  assign duck_start_x   = r_start_x;
  assign shots_left     = r_shots_left;
  assign hits           = r_hits;
  assign duck_idx       = r_duck_idx;
  assign round_num      = r_round;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_ctl_round.sv
// tb_ctl_round: self-checking bench for the duck round sequencer.
// Drives randomized hit/miss patterns and gaps, and checks outputs against
// expectations derived from the game rules (shot budget, hold frames,
// round pass threshold) plus an LFSR-based launch parameter model.
module tb_ctl_round;

  localparam int DUCKS = 10;
  localparam int HOLD  = 60;
  localparam int FLY   = 300;
  localparam int PASS  = 6;
  localparam int BASE  = 4;
`ifdef CTL_ROUND_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       start = 1'b0;
  logic       shot = 1'b0;
  logic       shot_on_duck = 1'b0;
  logic       duck_launch;
  logic       duck_fly_away;
  logic       duck_dead;
  logic       duck_direction;
  logic [4:0] duck_v_spd;
  logic [4:0] duck_h_spd;
  logic [9:0] duck_start_x;
  logic [1:0] shots_left;
  logic [3:0] hits;
  logic [3:0] duck_idx;
  logic [3:0] round_num;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int m_hits   = 0;
  int m_idx    = 0;
  int m_round  = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  ctl_round dut (
    .clk            (clk),
    .rst            (rst),
    .new_frame      (new_frame),
    .start          (start),
    .shot           (shot),
    .shot_on_duck   (shot_on_duck),
    .duck_launch    (duck_launch),
    .duck_fly_away  (duck_fly_away),
    .duck_dead      (duck_dead),
    .duck_direction (duck_direction),
    .duck_v_spd     (duck_v_spd),
    .duck_h_spd     (duck_h_spd),
    .duck_start_x   (duck_start_x),
    .shots_left     (shots_left),
    .hits           (hits),
    .duck_idx       (duck_idx),
    .round_num      (round_num),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  // One step of the 16-bit Fibonacci LFSR with taps 16,15,13,4
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

  // Random source model: m_prev is the value seen just before the last edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // Expected {direction, v_spd, h_spd, start_x} for a given random word/round
  function automatic logic [20:0] exp_params(input logic [15:0] rnd, input int rnum);
    int spd;
    int v;
    int h;
    int sx;
    spd = BASE;
    if (SPEEDUP) begin
      spd = BASE + 2 * (rnum - 1);
      if (spd > 27) spd = 27;
    end
    v = spd + int'(rnd[11:10]);
    if (v > 31) v = 31;
    h = spd + int'(rnd[13:12]);
    if (h > 31) h = 31;
    sx = 256 + int'(rnd[8:0]);
    return {rnd[9], v[4:0], h[4:0], sx[9:0]};
  endfunction

  // Drive one clock worth of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic nf, input logic sh, input logic od, input logic st);
    new_frame    = nf;
    shot         = sh;
    shot_on_duck = od;
    start        = st;
    @(posedge clk);
    #1;
    new_frame    = 1'b0;
    shot         = 1'b0;
    shot_on_duck = 1'b0;
    start        = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({duck_launch, duck_fly_away, duck_dead, duck_direction, duck_v_spd, duck_h_spd,
         duck_start_x, shots_left, hits, duck_idx, round_num, game_over} !== 39'd0)
      begin
      n_fail++;
      $display("[TB] FAIL reset_values: got launch=%b v=%0d sx=%0d shots=%0d round=%0d, expected all zero",
               duck_launch, duck_v_spd, duck_start_x, shots_left, round_num);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_hits  = 0;
    m_idx   = 0;
    m_round = 0;
  endtask

  task automatic test_start_launch();
    int gap;
    gap = $urandom_range(0, 7);
    repeat (gap) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({duck_launch, shots_left, round_num} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_ignores_shot: got launch=%b shots=%0d round=%0d, expected 0 0 0",
               duck_launch, shots_left, round_num);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    m_round = 1;
    m_hits  = 0;
    m_idx   = 0;
    n_checks++;
    if ({duck_launch, shots_left, hits, duck_idx, round_num} !== {1'b1, 2'd3, 4'd0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("[TB] FAIL first_launch: got launch=%b shots=%0d hits=%0d idx=%0d round=%0d, expected 1 3 0 0 1",
               duck_launch, shots_left, hits, duck_idx, round_num);
    end
    n_checks++;
    if ({duck_direction, duck_v_spd, duck_h_spd, duck_start_x} !== exp_params(m_prev, m_round)) begin
      n_fail++;
      $display("[TB] FAIL first_launch_params: got %h, expected %h",
               {duck_direction, duck_v_spd, duck_h_spd, duck_start_x}, exp_params(m_prev, m_round));
    end
  endtask

  // Hold phase, stray shot, NEXT and the following launch or round decision
  task automatic finish_duck();
    logic [1:0] held;
    held = {duck_dead, duck_fly_away};
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({hits, duck_dead, duck_fly_away} !== {4'(m_hits), held}) begin
      n_fail++;
      $display("[TB] FAIL hold_ignores_shot: got hits=%0d flags=%b%b, expected %0d %b",
               hits, duck_dead, duck_fly_away, m_hits, held);
    end
    frames(HOLD - 1);
    n_checks++;
    if ({duck_dead, duck_fly_away} !== held) begin
      n_fail++;
      $display("[TB] FAIL hold_before_last: got %b%b, expected %b", duck_dead, duck_fly_away, held);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({duck_dead, duck_fly_away, duck_launch} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL hold_exit: got dead=%b fly=%b launch=%b, expected 000",
               duck_dead, duck_fly_away, duck_launch);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    if (m_idx < DUCKS - 1) begin
      m_idx++;
    end else begin
      n_checks++;
      if ({duck_launch, game_over} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL round_end_cycle: got launch=%b over=%b, expected 00", duck_launch, game_over);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_hits >= PASS) begin
        m_round = (m_round < 15) ? m_round + 1 : 15;
        m_hits  = 0;
        m_idx   = 0;
      end else begin
        n_checks++;
        if ({game_over, duck_launch} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL game_over: got over=%b launch=%b, expected 1 0", game_over, duck_launch);
        end
        return;
      end
    end
    n_checks++;
    if ({duck_launch, shots_left, hits, duck_idx, round_num} !==
        {1'b1, 2'd3, 4'(m_hits), 4'(m_idx), 4'(m_round)}) begin
      n_fail++;
      $display("[TB] FAIL next_launch: got launch=%b shots=%0d hits=%0d idx=%0d round=%0d, expected 1 3 %0d %0d %0d",
               duck_launch, shots_left, hits, duck_idx, round_num, m_hits, m_idx, m_round);
    end
    n_checks++;
    if ({duck_direction, duck_v_spd, duck_h_spd, duck_start_x} !== exp_params(m_prev, m_round)) begin
      n_fail++;
      $display("[TB] FAIL next_launch_params: got %h, expected %h",
               {duck_direction, duck_v_spd, duck_h_spd, duck_start_x}, exp_params(m_prev, m_round));
    end
  endtask

  // One duck from its LAUNCH cycle: nmiss misses, then a hit or fly-away
  task automatic play_duck(input bit do_hit, input int nmiss);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (duck_launch !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL launch_pulse_width: got %b, expected 0", duck_launch);
    end
    for (int i = 0; i < nmiss; i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({shots_left, hits, duck_fly_away} !== {2'(2 - i), 4'(m_hits), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL miss_decrement: got shots=%0d hits=%0d fly=%b, expected %0d %0d 0",
                 shots_left, hits, duck_fly_away, 2 - i, m_hits);
      end
    end
    if (do_hit) begin
      repeat ($urandom_range(0, 2)) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      m_hits = (m_hits < 15) ? m_hits + 1 : 15;
      n_checks++;
      if ({duck_dead, duck_fly_away, hits, shots_left} !== {2'b10, 4'(m_hits), 2'(3 - nmiss)}) begin
        n_fail++;
        $display("[TB] FAIL hit: got dead=%b fly=%b hits=%0d shots=%0d, expected 1 0 %0d %0d",
                 duck_dead, duck_fly_away, hits, shots_left, m_hits, 3 - nmiss);
      end
    end else begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({duck_fly_away, duck_dead, shots_left, hits} !== {2'b10, 2'd0, 4'(m_hits)}) begin
        n_fail++;
        $display("[TB] FAIL out_of_shots: got fly=%b dead=%b shots=%0d hits=%0d, expected 1 0 0 %0d",
                 duck_fly_away, duck_dead, shots_left, hits, m_hits);
      end
    end
    finish_duck();
  endtask

  task automatic test_hit();
    play_duck(1'b1, $urandom_range(0, 2));
  endtask

  task automatic test_misses();
    play_duck(1'b0, 3);
  endtask

  // Timeout on the 300th frame; mode 0 plain, 1 hit on that frame, 2 miss on it
  task automatic test_timeout(input int mode);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    frames(FLY - 1);
    n_checks++;
    if ({duck_fly_away, duck_dead, shots_left} !== {2'b00, 2'd3}) begin
      n_fail++;
      $display("[TB] FAIL before_timeout: got fly=%b dead=%b shots=%0d, expected 0 0 3",
               duck_fly_away, duck_dead, shots_left);
    end
    if (mode == 1) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      m_hits = (m_hits < 15) ? m_hits + 1 : 15;
      n_checks++;
      if ({duck_dead, duck_fly_away, hits} !== {2'b10, 4'(m_hits)}) begin
        n_fail++;
        $display("[TB] FAIL timeout_with_hit: got dead=%b fly=%b hits=%0d, expected 1 0 %0d",
                 duck_dead, duck_fly_away, hits, m_hits);
      end
    end else begin
      cyc(1'b1, (mode == 2), 1'b0, 1'b0);
      n_checks++;
      if ({duck_fly_away, duck_dead, shots_left, hits} !==
          {2'b10, (mode == 2) ? 2'd2 : 2'd3, 4'(m_hits)}) begin
        n_fail++;
        $display("[TB] FAIL timeout_mode%0d: got fly=%b dead=%b shots=%0d hits=%0d, expected 1 0 %0d %0d",
                 mode, duck_fly_away, duck_dead, shots_left, hits, (mode == 2) ? 2 : 3, m_hits);
      end
    end
    finish_duck();
  endtask

  // Remaining five ducks of round 1 with at most one miss, so the round passes
  task automatic test_round_pass();
    int skip;
    skip = $urandom_range(0, 5);
    for (int k = 0; k < 5; k++) begin
      if (k == skip) play_duck(1'b0, 3);
      else play_duck(1'b1, $urandom_range(0, 2));
    end
  endtask

  // Exactly five hits in the round, one short of passing
  task automatic test_round_fail();
    int off;
    off = $urandom_range(0, 1);
    for (int k = 0; k < DUCKS; k++) begin
      if (((k + off) % 2) == 0) play_duck(1'b1, $urandom_range(0, 2));
      else play_duck(1'b0, 3);
    end
  endtask

  task automatic test_game_over_restart();
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({game_over, duck_launch, hits} !== {2'b10, 4'(m_hits)}) begin
      n_fail++;
      $display("[TB] FAIL game_over_hold: got over=%b launch=%b hits=%0d, expected 1 0 %0d",
               game_over, duck_launch, hits, m_hits);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({game_over, duck_launch} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL restart_idle: got over=%b launch=%b, expected 00", game_over, duck_launch);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    m_round = 1;
    m_hits  = 0;
    m_idx   = 0;
    n_checks++;
    if ({duck_launch, shots_left, hits, duck_idx, round_num} !== {1'b1, 2'd3, 4'd0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("[TB] FAIL restart_launch: got launch=%b shots=%0d hits=%0d idx=%0d round=%0d, expected 1 3 0 0 1",
               duck_launch, shots_left, hits, duck_idx, round_num);
    end
    n_checks++;
    if ({duck_direction, duck_v_spd, duck_h_spd, duck_start_x} !== exp_params(m_prev, m_round)) begin
      n_fail++;
      $display("[TB] FAIL restart_params: got %h, expected %h",
               {duck_direction, duck_v_spd, duck_h_spd, duck_start_x}, exp_params(m_prev, m_round));
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    frames(3);
    n_checks++;
    if ({duck_dead, hits} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_hit: got dead=%b hits=%0d, expected 1 1", duck_dead, hits);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({duck_launch, duck_fly_away, duck_dead, duck_direction, duck_v_spd, duck_h_spd,
         duck_start_x, shots_left, hits, duck_idx, round_num, game_over} !== 39'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got dead=%b sx=%0d shots=%0d hits=%0d round=%0d, expected all zero",
               duck_dead, duck_start_x, shots_left, hits, round_num);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({duck_launch, duck_dead, hits, round_num, game_over} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got launch=%b dead=%b hits=%0d round=%0d, expected all zero",
               duck_launch, duck_dead, hits, round_num);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({duck_direction, duck_v_spd, duck_h_spd, duck_start_x} !== exp_params(m_prev, 1)) begin
      n_fail++;
      $display("[TB] FAIL post_reset_params: got %h, expected %h",
               {duck_direction, duck_v_spd, duck_h_spd, duck_start_x}, exp_params(m_prev, 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting ctl_round bench");
    test_reset();
    test_start_launch();
    test_hit();
    test_misses();
    test_timeout(0);
    test_timeout(1);
    test_timeout(2);
    test_round_pass();
    test_round_fail();
    test_game_over_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
